// File: rtl/ws2812_pkg.sv
// Shared types and constants for the ws2812 pixel-write scheduler.
package ws2812_pkg;

    // Width of one GRB-packed pixel colour word.
    localparam int RGB_W = 24;

    // Scheduler top-level states.
    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    // Requester identities. The bit value matches the requester's position in
    // the arbiter request/grant vectors.
    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_t;

    // Common colours, GRB-packed: green in [23:16], red in [15:8], blue in [7:0].
    localparam logic [RGB_W-1:0] COLOUR_OFF   = 24'h000000;
    localparam logic [RGB_W-1:0] COLOUR_GREEN = 24'hff0000;
    localparam logic [RGB_W-1:0] COLOUR_RED   = 24'h00ff00;
    localparam logic [RGB_W-1:0] COLOUR_BLUE  = 24'h0000ff;
    localparam logic [RGB_W-1:0] COLOUR_WHITE = 24'hffffff;

    // Packs separate R/G/B bytes into the GRB order the ws2812 core expects.
    function automatic logic [RGB_W-1:0] grb_pack(
        input logic [7:0] r,
        input logic [7:0] g,
        input logic [7:0] b
    );
        return {g, r, b};
    endfunction

endpackage

// File: rtl/ws2812_write_sched_arb.sv
// Two-way round-robin arbiter. Grant is combinational from req/enable and the
// registered last-winner pointer; the pointer only moves when a grant is issued.
import ws2812_pkg::*;

module rr_arb2 (
    input  logic       CLK,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       enable,
    output logic [1:0] grant,
    output logic       last
);

    // Last requester that won (REQ_A = 0, REQ_B = 1).
    logic last_reg;

    // A requester wins if it asks and either the other one is quiet or the
    // other one won last time.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_grant
            assign grant[gi] = enable && req[gi] &&
                               (!req[1-gi] || (last_reg != 1'(gi)));
        end
    endgenerate

    assign last = last_reg;

    // Track the most recent winner; reset points at B so A wins the first tie.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            last_reg <= REQ_B;
        end else if (|grant) begin
            last_reg <= grant[1] ? REQ_B : REQ_A;
        end
    end

endmodule

// File: rtl/ws2812_write_sched.sv
// Write scheduler for the ws2812 pixel-write port. Arbitrates two requesters
// round-robin and runs a FILL sequence that paints every LED one colour.
// Every output comes straight from a register.
import ws2812_pkg::*;

module ws2812_write_sched #(
    parameter int NUM_LEDS = 8,
    parameter int LED_W    = 8
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             a_req,
    input  logic [LED_W-1:0] a_led,
    input  logic [23:0]      a_rgb,
    output logic             a_ack,
    input  logic             b_req,
    input  logic [LED_W-1:0] b_led,
    input  logic [23:0]      b_rgb,
    output logic             b_ack,
    input  logic             fill_req,
    input  logic [23:0]      fill_rgb,
    output logic             fill_busy,
    output logic             wr_en,
    output logic [LED_W-1:0] wr_led,
    output logic [23:0]      wr_rgb,
    output logic             err
);

    // Counter is one bit wider than the index so NUM_LEDS=256 is representable.
    localparam logic [LED_W:0] NUM_LEDS_C = (LED_W+1)'(NUM_LEDS);
    localparam logic [LED_W:0] LAST_IDX   = NUM_LEDS_C - (LED_W+1)'(1);

    state_t           state_reg;
    logic [LED_W:0]   cnt_reg;
    logic [RGB_W-1:0] fill_rgb_reg;

    logic             a_ack_reg;
    logic             b_ack_reg;
    logic             fill_busy_reg;
    logic             wr_en_reg;
    logic [LED_W-1:0] wr_led_reg;
    logic [RGB_W-1:0] wr_rgb_reg;
    logic             err_reg;

    // Accepted request waiting one cycle to be issued on the write port.
    logic             pend_valid_reg;
    logic             pend_bad_reg;
    logic [LED_W-1:0] pend_led_reg;
    logic [RGB_W-1:0] pend_rgb_reg;

    logic [1:0]       req_raw;
    logic [1:0]       ack_vec;
    logic [1:0]       req_masked;
    logic [1:0]       grant;
    logic             arb_enable;
    logic             arb_last;
    logic [LED_W-1:0] sel_led;
    logic [RGB_W-1:0] sel_rgb;

    assign req_raw = {b_req, a_req};
    assign ack_vec = {b_ack_reg, a_ack_reg};

    // A requester still sees its own ack this cycle and has not had a chance
    // to drop req yet, so mask it out to avoid accepting the same write twice.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_mask
            assign req_masked[gi] = req_raw[gi] & ~ack_vec[gi];
        end
    endgenerate

    // Requests are only served in IDLE, and a fill strobe takes precedence.
    assign arb_enable = (state_reg == IDLE) && !fill_req;

    rr_arb2 u_arb (
        .CLK    (CLK),
        .reset  (reset),
        .req    (req_masked),
        .enable (arb_enable),
        .grant  (grant),
        .last   (arb_last)
    );

    // Data of whichever requester the arbiter picked this cycle.
    assign sel_led = grant[1] ? b_led : a_led;
    assign sel_rgb = grant[1] ? b_rgb : a_rgb;

    // Scheduler FSM, fill counter, request pipeline and all output registers.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            fill_rgb_reg   <= COLOUR_OFF;
            a_ack_reg      <= 1'b0;
            b_ack_reg      <= 1'b0;
            fill_busy_reg  <= 1'b0;
            wr_en_reg      <= 1'b0;
            wr_led_reg     <= '0;
            wr_rgb_reg     <= COLOUR_OFF;
            err_reg        <= 1'b0;
            pend_valid_reg <= 1'b0;
            pend_bad_reg   <= 1'b0;
            pend_led_reg   <= '0;
            pend_rgb_reg   <= COLOUR_OFF;
        end else begin
            // Pulse outputs default low; wr_led/wr_rgb hold.
            a_ack_reg      <= 1'b0;
            b_ack_reg      <= 1'b0;
            wr_en_reg      <= 1'b0;
            err_reg        <= 1'b0;
            pend_valid_reg <= 1'b0;

            // Issue the request accepted last cycle. A fill cannot be writing
            // now, since it only starts the cycle after the strobe is taken.
            if (pend_valid_reg) begin
                if (pend_bad_reg) begin
                    err_reg <= 1'b1;
                end else begin
                    wr_en_reg  <= 1'b1;
                    wr_led_reg <= pend_led_reg;
                    wr_rgb_reg <= pend_rgb_reg;
                end
            end

            case (state_reg)
                IDLE: begin
                    if (fill_req) begin
                        fill_rgb_reg  <= fill_rgb;
                        cnt_reg       <= '0;
                        fill_busy_reg <= 1'b1;
                        state_reg     <= FILL;
                    end else if (|grant) begin
                        a_ack_reg      <= grant[0];
                        b_ack_reg      <= grant[1];
                        pend_valid_reg <= 1'b1;
                        pend_led_reg   <= sel_led;
                        pend_rgb_reg   <= sel_rgb;
                        pend_bad_reg   <= ({1'b0, sel_led} >= NUM_LEDS_C);
                    end
                end
                FILL: begin
                    // One pixel per cycle; fill_req is ignored while here.
                    wr_en_reg  <= 1'b1;
                    wr_led_reg <= cnt_reg[LED_W-1:0];
                    wr_rgb_reg <= fill_rgb_reg;
                    cnt_reg    <= cnt_reg + (LED_W+1)'(1);
                    if (cnt_reg == LAST_IDX) begin
                        fill_busy_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign a_ack     = a_ack_reg;
    assign b_ack     = b_ack_reg;
    assign fill_busy = fill_busy_reg;
    assign wr_en     = wr_en_reg;
    assign wr_led    = wr_led_reg;
    assign wr_rgb    = wr_rgb_reg;
    assign err       = err_reg;

endmodule

// File: tb/tb_ws2812_write_sched.sv
// Directed bench for ws2812_write_sched with a scoreboard of expected writes.
module tb_ws2812_write_sched;

    logic        CLK;
    logic        reset;
    logic        a_req;
    logic [7:0]  a_led;
    logic [23:0] a_rgb;
    logic        a_ack;
    logic        b_req;
    logic [7:0]  b_led;
    logic [23:0] b_rgb;
    logic        b_ack;
    logic        fill_req;
    logic [23:0] fill_rgb;
    logic        fill_busy;
    logic        wr_en;
    logic [7:0]  wr_led;
    logic [23:0] wr_rgb;
    logic        err;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic        is_err;
        logic [7:0]  led;
        logic [23:0] rgb;
    } exp_t;

    exp_t sb_q[$];

    ws2812_write_sched #(.NUM_LEDS(8), .LED_W(8)) dut (
        .CLK       (CLK),
        .reset     (reset),
        .a_req     (a_req),
        .a_led     (a_led),
        .a_rgb     (a_rgb),
        .a_ack     (a_ack),
        .b_req     (b_req),
        .b_led     (b_led),
        .b_rgb     (b_rgb),
        .b_ack     (b_ack),
        .fill_req  (fill_req),
        .fill_rgb  (fill_rgb),
        .fill_busy (fill_busy),
        .wr_en     (wr_en),
        .wr_led    (wr_led),
        .wr_rgb    (wr_rgb),
        .err       (err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic push_wr(input logic [7:0] led, input logic [23:0] rgb);
        exp_t e;
        e.is_err = 1'b0;
        e.led    = led;
        e.rgb    = rgb;
        sb_q.push_back(e);
    endtask

    task automatic push_err();
        exp_t e;
        e.is_err = 1'b1;
        e.led    = 8'h00;
        e.rgb    = 24'h0;
        sb_q.push_back(e);
    endtask

    // Write-port monitor: every wr_en or err pulse must match the head of the scoreboard.
    always @(negedge CLK) begin
        if (wr_en === 1'b1 || err === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_write", {7'd0, wr_en, err, wr_led, 15'd0}, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if (e.is_err) begin
                    check("err_flag", 32'(err), 32'd1);
                    check("err_no_wr", 32'(wr_en), 32'd0);
                    $display("txn: err pulse (index out of range)");
                end else begin
                    check("wr_en_vs_err", 32'(err), 32'd0);
                    check("wr_led", 32'(wr_led), 32'(e.led));
                    check("wr_rgb", 32'(wr_rgb), 32'(e.rgb));
                    $display("txn: write led=%0d rgb=%06h", wr_led, wr_rgb);
                end
            end
        end
    end

    initial begin
        logic [7:0]  a_leds [3];
        logic [23:0] a_rgbs [3];
        logic [7:0]  b_leds [3];
        logic [23:0] b_rgbs [3];
        int ai;
        int bi;

        a_leds = '{8'd0, 8'd1, 8'd2};
        a_rgbs = '{24'h110000, 24'h220000, 24'h330000};
        b_leds = '{8'd4, 8'd5, 8'd6};
        b_rgbs = '{24'h000011, 24'h000022, 24'h000033};

        reset    = 1'b1;
        a_req    = 1'b0;
        a_led    = 8'd0;
        a_rgb    = 24'd0;
        b_req    = 1'b0;
        b_led    = 8'd0;
        b_rgb    = 24'd0;
        fill_req = 1'b0;
        fill_rgb = 24'd0;
        tick();
        tick();

        // Reset state: all outputs low.
        check("rst_a_ack", 32'(a_ack), 32'd0);
        check("rst_b_ack", 32'(b_ack), 32'd0);
        check("rst_fill_busy", 32'(fill_busy), 32'd0);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_wr_led", 32'(wr_led), 32'd0);
        check("rst_wr_rgb", 32'(wr_rgb), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        reset = 1'b0;
        tick();

        // Single A request: ack next cycle, write one cycle later.
        a_req = 1'b1;
        a_led = 8'd3;
        a_rgb = 24'h7f0000;
        push_wr(8'd3, 24'h7f0000);
        tick();
        check("t1_a_ack", 32'(a_ack), 32'd1);
        check("t1_b_ack", 32'(b_ack), 32'd0);
        check("t1_wr_en_lat", 32'(wr_en), 32'd0);
        a_req = 1'b0;
        tick();
        check("t1_wr_en", 32'(wr_en), 32'd1);
        check("t1_a_ack_pulse", 32'(a_ack), 32'd0);
        tick();
        check("t1_wr_idle", 32'(wr_en), 32'd0);
        check("t1_hold_led", 32'(wr_led), 32'd3);

        // B with out-of-range index: acked, then err with no write.
        b_req = 1'b1;
        b_led = 8'd8;
        b_rgb = 24'h0000ff;
        push_err();
        tick();
        check("t5_b_ack", 32'(b_ack), 32'd1);
        b_req = 1'b0;
        tick();
        check("t5_err", 32'(err), 32'd1);
        check("t5_wr_en", 32'(wr_en), 32'd0);
        tick();

        // A and B held high: acks alternate A,B,A,B,A,B, writes back-to-back.
        ai = 0;
        bi = 0;
        a_req = 1'b1;
        a_led = a_leds[0];
        a_rgb = a_rgbs[0];
        b_req = 1'b1;
        b_led = b_leds[0];
        b_rgb = b_rgbs[0];
        for (int k = 0; k < 3; k++) begin
            push_wr(a_leds[k], a_rgbs[k]);
            push_wr(b_leds[k], b_rgbs[k]);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            check("t2_a_ack", 32'(a_ack), ((i % 2) == 0) ? 32'd1 : 32'd0);
            check("t2_b_ack", 32'(b_ack), ((i % 2) == 1) ? 32'd1 : 32'd0);
            check("t2_wr_en", 32'(wr_en), (i > 0) ? 32'd1 : 32'd0);
            if (a_ack === 1'b1) begin
                ai++;
                if (ai >= 3) a_req = 1'b0;
                else begin
                    a_led = a_leds[ai];
                    a_rgb = a_rgbs[ai];
                end
            end
            if (b_ack === 1'b1) begin
                bi++;
                if (bi >= 3) b_req = 1'b0;
                else begin
                    b_led = b_leds[bi];
                    b_rgb = b_rgbs[bi];
                end
            end
        end
        a_req = 1'b0;
        b_req = 1'b0;
        tick();
        check("t2_last_wr", 32'(wr_en), 32'd1);
        tick();
        check("t2_done", 32'(wr_en), 32'd0);

        // FILL: 8 writes 0..7, busy for 8 cycles; a second strobe is ignored.
        fill_req = 1'b1;
        fill_rgb = 24'h007f00;
        for (int k = 0; k < 8; k++) push_wr(8'(k), 24'h007f00);
        tick();
        fill_req = 1'b0;
        fill_rgb = 24'h0000aa;
        check("t3_busy_start", 32'(fill_busy), 32'd1);
        check("t3_no_wr_yet", 32'(wr_en), 32'd0);
        for (int k = 0; k < 7; k++) begin
            fill_req = (k == 3);
            tick();
            fill_req = 1'b0;
            check("t3_busy", 32'(fill_busy), 32'd1);
            check("t3_wr_en", 32'(wr_en), 32'd1);
        end
        tick();
        check("t3_busy_drop", 32'(fill_busy), 32'd0);
        check("t3_last_wr", 32'(wr_en), 32'd1);
        tick();
        check("t3_idle", 32'(wr_en), 32'd0);
        check("t3_no_refill", 32'(fill_busy), 32'd0);
        tick();

        // fill_req and a_req together: fill first, then A.
        fill_req = 1'b1;
        fill_rgb = 24'h00007f;
        a_req    = 1'b1;
        a_led    = 8'd5;
        a_rgb    = 24'h123456;
        for (int k = 0; k < 8; k++) push_wr(8'(k), 24'h00007f);
        push_wr(8'd5, 24'h123456);
        tick();
        fill_req = 1'b0;
        check("t4_busy", 32'(fill_busy), 32'd1);
        check("t4_no_ack", 32'(a_ack), 32'd0);
        for (int k = 0; k < 8; k++) begin
            tick();
            check("t4_ack_stall", 32'(a_ack), 32'd0);
        end
        check("t4_busy_drop", 32'(fill_busy), 32'd0);
        tick();
        check("t4_a_ack", 32'(a_ack), 32'd1);
        a_req = 1'b0;
        tick();
        check("t4_a_wr", 32'(wr_en), 32'd1);
        tick();

        // Reset in the middle of a fill: async clear, nothing resumes.
        fill_req = 1'b1;
        fill_rgb = 24'h7f7f7f;
        for (int k = 0; k < 4; k++) push_wr(8'(k), 24'h7f7f7f);
        tick();
        fill_req = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        check("t6_mid_fill", 32'(fill_busy), 32'd1);
        reset = 1'b1;
        #1;
        check("t6_async_busy", 32'(fill_busy), 32'd0);
        check("t6_async_wr_en", 32'(wr_en), 32'd0);
        check("t6_async_wr_led", 32'(wr_led), 32'd0);
        check("t6_async_wr_rgb", 32'(wr_rgb), 32'd0);
        tick();
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t6_no_resume", 32'(wr_en), 32'd0);
            check("t6_idle", 32'(fill_busy), 32'd0);
        end
        a_req = 1'b1;
        a_led = 8'd7;
        a_rgb = 24'h010203;
        b_req = 1'b1;
        b_led = 8'd6;
        b_rgb = 24'h040506;
        push_wr(8'd7, 24'h010203);
        tick();
        check("t6_tie_a", 32'(a_ack), 32'd1);
        check("t6_tie_b", 32'(b_ack), 32'd0);
        a_req = 1'b0;
        b_req = 1'b0;
        tick();
        tick();
        check("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
